// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART transmitter with FIFO.
// Optional parity stage is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

   localparam int CLK_DIV_DEF   = 868;
   localparam int DATA_BITS_DEF = 8;
   localparam int DEPTH_DEF     = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; push is ignored when full,
// pop is ignored when empty; head word is visible on data_o.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a sync_fifo; frames back-to-back while data waits.
// Define UART_TX_PARITY_EN to insert a parity bit after the payload.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = CLK_DIV_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                   clk,
   input  logic                   btnc,
   input  logic                   wr_en,
   input  logic [DATA_BITS-1:0]   wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   busy,
   output logic                   tx
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
       STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_tx_fifo: parameter out of range");
   end

   uart_state_e            state_q, state_d;
   logic [DW-1:0]          div_q, div_d;
   logic [2:0]             bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   ovf_q;
   logic                   pop;
   logic                   load;
   logic                   bit_end;
   logic [DATA_BITS-1:0]   fifo_data;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
`ifdef UART_TX_PARITY_EN
   logic                   par_q, par_d;
`endif

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (btnc),
      .push_i  (wr_en),
      .data_i  (wr_data),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign full     = fifo_full;
   assign empty    = fifo_empty;
   assign count    = fifo_count;
   assign overflow = ovf_q;
   assign busy     = (state_q != ST_IDLE);
   assign tx       = tx_q;
   assign bit_end  = (div_q == '0);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      load    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (!bit_end) div_d = div_q - DW'(1);
      unique case (state_q)
         ST_IDLE: load = !fifo_empty;
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               div_d   = DIV_LAST;
               bit_d   = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               div_d = DIV_LAST;
               if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = par_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
                  bit_d   = '0;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               div_d   = DIV_LAST;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (bit_q != STOP_LAST) begin
                  bit_d = bit_q + 3'd1;
                  div_d = DIV_LAST;
               end else if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
      // a pop always opens a new frame with the start bit
      if (load) begin
         pop     = 1'b1;
         state_d = ST_START;
         div_d   = DIV_LAST;
         bit_d   = '0;
         shift_d = fifo_data;
         tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_d   = (^fifo_data) ^ (PARITY_ODD != 0);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (btnc) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_q | (wr_en & fifo_full);
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule
